// File: rtl/ec_fifo_pkg.sv
// Shared types and sizing helpers for the sram_fifo read path.
package ec_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rd_state_e;

  localparam int unsigned SRAM_WRAP_WIDTH_DEF = 32;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_fifo_reader_buf.sv
// Circular skid buffer for returned SRAM words; head entry is presented from registers.
module sram_fifo_reader_buf
  import ec_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = SRAM_WRAP_WIDTH_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [cnt_w(DEPTH)-1:0]  occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram_fifo_reader.sv
// Burst read master for sram_fifo: credit-limited requests into a skid buffer, drained on valid/ready.
// Optional SRAM_FIFO_READER_STATS_EN adds saturating stall counters.
module sram_fifo_reader
  import ec_fifo_pkg::*;
#(
  parameter int unsigned SRAM_WRAP_WIDTH = SRAM_WRAP_WIDTH_DEF,
  parameter int unsigned BUF_DEPTH       = 4,
  parameter int unsigned RD_LAT          = 1,
  parameter int unsigned LEN_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           burst_len,
  output logic                       busy,
  output logic                       done,
  output logic                       fifo_rd_req,
  input  logic                       fifo_empty,
  input  logic                       fifo_rd_data_val,
  input  logic [SRAM_WRAP_WIDTH-1:0] fifo_rd_data,
  output logic                       out_valid,
  output logic [SRAM_WRAP_WIDTH-1:0] out_data,
  input  logic                       out_ready,
  output logic                       err_unexp_rsp
`ifdef SRAM_FIFO_READER_STATS_EN
  ,
  output logic [31:0]                stat_empty_stall,
  output logic [31:0]                stat_bp_stall
`endif
);

  localparam int unsigned CNT_W = cnt_w(BUF_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Below this depth the credit loop caps throughput under one word per cycle.
  if (BUF_DEPTH < RD_LAT + 2) begin : g_below_full_rate
  end

  rd_state_e          state;
  rd_state_e          state_nxt;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   delivered;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   occupancy;

  logic start_acc;
  logic more;
  logic credit_ok;
  logic rsp_ok;
  logic xfer;
  logic last_xfer;

  assign start_acc = (state == IDLE) && start;
  assign more      = issued < len;
  assign credit_ok = (SUM_W'(outstanding) + SUM_W'(occupancy)) < SUM_W'(BUF_DEPTH);
  assign fifo_rd_req = (state == RUN) && !fifo_empty && more && credit_ok;
  assign rsp_ok    = fifo_rd_data_val && (outstanding != '0);
  assign out_valid = occupancy != '0;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && ((delivered + LEN_W'(1)) == len);
  assign busy      = state == RUN;
  assign done      = state == DONE;

  sram_fifo_reader_buf #(
    .WIDTH (SRAM_WRAP_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_ok),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .head_data (out_data),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
      RUN:     if ((delivered == len) || last_xfer) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len           <= '0;
      issued        <= '0;
      delivered     <= '0;
      outstanding   <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (start_acc) begin
        len       <= burst_len;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (fifo_rd_req) issued    <= issued + LEN_W'(1);
        if (xfer)        delivered <= delivered + LEN_W'(1);
      end
      case ({fifo_rd_req, rsp_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (fifo_rd_data_val && (outstanding == '0)) err_unexp_rsp <= 1'b1;
    end
  end

`ifdef SRAM_FIFO_READER_STATS_EN
  logic stall_run;
  assign stall_run = (state == RUN) && more;

  // Stall attribution counters, each charged only when its cause is the sole blocker.
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      stat_empty_stall <= '0;
      stat_bp_stall    <= '0;
    end else begin
      if (stall_run && fifo_empty && credit_ok && (stat_empty_stall != '1))
        stat_empty_stall <= stat_empty_stall + 32'd1;
      if (stall_run && !fifo_empty && !credit_ok && (stat_bp_stall != '1))
        stat_bp_stall <= stat_bp_stall + 32'd1;
    end
  end
`endif

endmodule
